imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
//  Inverse of the immediate generator: packs register fields and a sign-extended
//  64-bit immediate into a 32-bit RV64I instruction word (load, store, branch, JAL).
//  Sits between the test-program assembler/ucode source and instruction memory.
//  Range/alignment-checks each immediate; buffers results in a small output FIFO.
// PARAMETERS
//  XLEN        64  immediate input width
//  FIFO_DEPTH  2   output buffer entries (power of two, >=2)
//  CNT_W       16  width of statistics counters
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       request valid
//  in_ready   out  1       request accepted when in_valid&&in_ready
//  in_opcode  in   7       0000011 load(I), 0100011 store(S), 1100011 branch(B), 1101111 JAL(J)
//  in_rd      in   5       destination (I, J)
//  in_rs1     in   5       source 1 (I, S, B)
//  in_rs2     in   5       source 2 (S, B)
//  in_funct3  in   3       funct3 (I, S, B; ignored for J)
//  in_imm     in   XLEN    sign-extended immediate; byte offset for B/J
//  out_valid  out  1       output entry valid
//  out_ready  in   1       consumer takes entry when out_valid&&out_ready
//  out_instr  out  32      encoded instruction word
//  out_err    out  1       entry is an error substitute (see BEHAVIOUR)
//  enc_count  out  CNT_W   good encodes accepted, saturating
//  err_count  out  CNT_W   error entries accepted, saturating
// BEHAVIOUR
//  Reset (rst_n low, async): FIFO empty, out_valid=0, out_instr=0, out_err=0,
//   counters=0, in_ready=0. in_ready rises first clk edge after deassertion.
//  in_ready = occupancy<FIFO_DEPTH (registered; no comb path from out_ready).
//  Encode combinational on input; written into FIFO on accepting edge.
//  Latency: accepted at edge N -> visible on out_* after edge N (empty FIFO).
//  Encodings (standard RISC-V): I: {imm[11:0],rs1,f3,rd,op};
//   S: {imm[11:5],rs2,rs1,f3,imm[4:0],op};
//   B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op};
//   J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
//  Checks: I/S: in_imm == sext(imm[11:0]); B: == sext(imm[12:0]) and imm[0]=0;
//   J: == sext(imm[20:0]) and imm[0]=0; opcode must be one of the four.
//  Any check fails: entry = 32'h0000_0013 (NOP) with out_err=1; still enqueued.
//  FIFO: in-order, head drives out_*; out_instr/out_err hold while out_valid&&!out_ready.
//   Simultaneous push+pop: occupancy unchanged, order preserved. Full: no push.
//   Empty: out_valid=0, out_instr/out_err hold last popped value.
//  Pointers wrap modulo FIFO_DEPTH.
//  Counters: on accept, enc_count++ if no error else err_count++; saturate at all-ones.
//  Reset mid-operation: FIFO contents discarded, no partial entry emitted.
// TESTING
//  ld x5,-8(x2): op=03 f3=3 rd=5 rs1=2 imm=-8 -> out_instr=FF813283, out_err=0, 1 cycle latency
//  sd x6,16(x2): op=23 f3=3 rs1=2 rs2=6 imm=16 -> 00613823; beq x1,x2,-4 -> FE208EE3
//  jal x1,2048: op=6F rd=1 imm=0x800 -> 001000EF; enc_count increments per good encode
//  B imm=4096 / B imm=3 / I imm=2048 / op=0110011 -> 00000013, out_err=1, err_count +1 each
//  out_ready=0, push 3 -> 2 accepted, in_ready=0; release -> drain in order, then in_ready=1
//  continuous in_valid/out_ready=1 -> 1 result/cycle; pulse rst_n low mid-stream -> out_valid=0, counters 0

Source files
------------

// File: rtl/imm_encoder.sv
// RV64I immediate encoder: packs register fields and a sign-extended immediate
// into load/store/branch/JAL instruction words, range-checked, through a small FIFO.
module imm_encoder #(
  parameter int XLEN       = 64,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // True when v equals the sign extension of its low 'bits' bits.
  function automatic logic fits_signed(input logic [XLEN-1:0] v, input int bits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < XLEN; i++) begin
      if (i >= bits && v[i] != v[bits-1]) ok = 1'b0;
    end
    return ok;
  endfunction

  logic [31:0]      enc_instr;
  logic             enc_ok;
  logic             enc_err;

  logic [31:0]      mem_instr [FIFO_DEPTH];
  logic             mem_err   [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [OW-1:0]    count;
  logic [OW-1:0]    count_next;
  logic             in_ready_q;
  logic [31:0]      last_instr;
  logic             last_err;
  logic             push;
  logic             pop;

  always_comb begin
    enc_instr = NOP_INSTR;
    enc_ok    = 1'b0;
    case (in_opcode)
      OP_LOAD: begin
        enc_ok    = fits_signed(in_imm, 12);
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      OP_STORE: begin
        enc_ok    = fits_signed(in_imm, 12);
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      OP_BRANCH: begin
        enc_ok    = fits_signed(in_imm, 13) && !in_imm[0];
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
      end
      OP_JAL: begin
        enc_ok    = fits_signed(in_imm, 21) && !in_imm[0];
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      end
      default: enc_ok = 1'b0;
    endcase
    if (!enc_ok) enc_instr = NOP_INSTR;
    enc_err = !enc_ok;
  end

  assign in_ready  = in_ready_q;
  assign push      = in_valid && in_ready_q;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  // When empty, the outputs hold whatever was last popped.
  assign out_instr = out_valid ? mem_instr[rd_ptr] : last_instr;
  assign out_err   = out_valid ? mem_err[rd_ptr]   : last_err;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + OW'(1);
      2'b01:   count_next = count - OW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= enc_instr;
      mem_err[wr_ptr]   <= enc_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b0;
      last_instr <= '0;
      last_err   <= 1'b0;
      enc_count  <= '0;
      err_count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PW'(1);
        last_instr <= mem_instr[rd_ptr];
        last_err   <= mem_err[rd_ptr];
      end
      count      <= count_next;
      in_ready_q <= (count_next < OW'(FIFO_DEPTH));
      if (push) begin
        if (enc_err) begin
          if (err_count != '1) err_count <= err_count + CNT_W'(1);
        end else begin
          if (enc_count != '1) enc_count <= enc_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder: encodings, range errors,
// backpressure, streaming throughput and asynchronous reset mid-stream.
module tb_imm_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  int checks;
  int passed;

  // Directed vectors with hand-encoded expected instruction words.
  localparam int NV = 10;
  logic [6:0]  v_op   [NV];
  logic [2:0]  v_f3   [NV];
  logic [4:0]  v_rd   [NV];
  logic [4:0]  v_rs1  [NV];
  logic [4:0]  v_rs2  [NV];
  logic [63:0] v_imm  [NV];
  logic [31:0] v_exp  [NV];
  logic        v_err  [NV];

  imm_encoder #(.XLEN(64), .FIFO_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
  endtask

  task automatic setVec(input int idx, input int op, input int f3, input int rd,
                        input int rs1, input int rs2, input logic [63:0] imm,
                        input logic [31:0] exp, input logic err);
    v_op[idx]  = 7'(op);
    v_f3[idx]  = 3'(f3);
    v_rd[idx]  = 5'(rd);
    v_rs1[idx] = 5'(rs1);
    v_rs2[idx] = 5'(rs2);
    v_imm[idx] = imm;
    v_exp[idx] = exp;
    v_err[idx] = err;
  endtask

  task automatic applyStimulus(input int idx);
    in_opcode = v_op[idx];
    in_funct3 = v_f3[idx];
    in_rd     = v_rd[idx];
    in_rs1    = v_rs1[idx];
    in_rs2    = v_rs2[idx];
    in_imm    = v_imm[idx];
    in_valid  = 1'b1;
  endtask

  // One request through an otherwise idle encoder with the consumer ready.
  task automatic sendOne(input int idx);
    @(negedge clk);
    applyStimulus(idx);
    @(negedge clk);
    checkOutput($sformatf("valid_%0d", idx), 64'(out_valid), 64'd1);
    checkOutput($sformatf("instr_%0d", idx), 64'(out_instr), 64'(v_exp[idx]));
    checkOutput($sformatf("err_%0d", idx), 64'(out_err), 64'(v_err[idx]));
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("drained_%0d", idx), 64'(out_valid), 64'd0);
    checkOutput($sformatf("hold_%0d", idx), 64'(out_instr), 64'(v_exp[idx]));
  endtask

  initial begin
    checks = 0;
    passed = 0;
    setVec(0, 'h03, 3, 5, 2, 0, -64'sd8,   32'hFF81_3283, 1'b0);
    setVec(1, 'h23, 3, 0, 2, 6, 64'd16,    32'h0061_3823, 1'b0);
    setVec(2, 'h63, 0, 0, 1, 2, -64'sd4,   32'hFE20_8EE3, 1'b0);
    setVec(3, 'h6F, 0, 1, 0, 0, 64'd2048,  32'h0010_00EF, 1'b0);
    setVec(4, 'h63, 0, 0, 1, 2, 64'd4096,  32'h0000_0013, 1'b1);
    setVec(5, 'h63, 0, 0, 1, 2, 64'd3,     32'h0000_0013, 1'b1);
    setVec(6, 'h03, 3, 5, 2, 0, 64'd2048,  32'h0000_0013, 1'b1);
    setVec(7, 'h33, 0, 1, 2, 3, 64'd0,     32'h0000_0013, 1'b1);
    setVec(8, 'h03, 3, 1, 0, 0, 64'd2047,  32'h7FF0_3083, 1'b0);
    setVec(9, 'h03, 3, 1, 0, 0, -64'sd2048, 32'h8000_3083, 1'b0);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_opcode = '0; in_funct3 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_instr", 64'(out_instr), 64'd0);
    checkOutput("rst_out_err", 64'(out_err), 64'd0);
    checkOutput("rst_enc_count", 64'(enc_count), 64'd0);
    checkOutput("rst_err_count", 64'(err_count), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_before_edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    checkOutput("ready_after_edge", 64'(in_ready), 64'd1);

    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) sendOne(i);
    checkOutput("enc_count_directed", 64'(enc_count), 64'd6);
    checkOutput("err_count_directed", 64'(err_count), 64'd4);

    // Backpressure: three requests against a stalled consumer.
    out_ready = 1'b0;
    @(negedge clk);
    applyStimulus(0);
    @(negedge clk);
    checkOutput("bp_ready_1", 64'(in_ready), 64'd1);
    applyStimulus(1);
    @(negedge clk);
    checkOutput("bp_ready_full", 64'(in_ready), 64'd0);
    applyStimulus(3);
    @(negedge clk);
    checkOutput("bp_still_full", 64'(in_ready), 64'd0);
    checkOutput("bp_head_hold", 64'(out_instr), 64'(v_exp[0]));
    checkOutput("bp_enc_count", 64'(enc_count), 64'd8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_second", 64'(out_instr), 64'(v_exp[1]));
    checkOutput("bp_second_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_ready_back", 64'(in_ready), 64'd1);
    @(negedge clk);
    checkOutput("bp_empty", 64'(out_valid), 64'd0);
    checkOutput("bp_enc_final", 64'(enc_count), 64'd8);

    // Streaming: one result per cycle, each visible the cycle after acceptance.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        checkOutput($sformatf("stream_instr_%0d", i - 1), 64'(out_instr), 64'(v_exp[i-1]));
        checkOutput($sformatf("stream_ready_%0d", i - 1), 64'(in_ready), 64'd1);
      end
      applyStimulus(i);
      @(negedge clk);
    end
    checkOutput("stream_instr_3", 64'(out_instr), 64'(v_exp[3]));
    applyStimulus(4);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_enc", 64'(enc_count), 64'd0);
    checkOutput("midrst_err", 64'(err_count), 64'd0);
    checkOutput("midrst_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postrst_valid", 64'(out_valid), 64'd0);
    sendOne(2);
    checkOutput("postrst_enc", 64'(enc_count), 64'd1);
    checkOutput("postrst_err", 64'(err_count), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
